// File: rtl/fft_repeating_buffer_if.sv
// Sample stream bundle for the overlapping-frame buffer: input strobe/data,
// output frame stream with ready/valid/last handshake and the sticky overflow flag.
interface fft_repeating_buffer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_ready;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  o_last;
  logic                  o_overflow;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_data, o_valid, o_last, o_overflow
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_data, o_valid, o_last, o_overflow
  );
endinterface

// File: rtl/fft_repeating_buffer.sv
// Overlapping frame generator: first o_valid 2 edges after the trigger sample;
// input never stalls, output holds on !i_ready via a 2-stage read/output pipeline.
module fft_repeating_buffer #(
  parameter int FFT_LENGTH          = 1024,
  parameter int NEW_SAMPLES_PER_FFT = 256,
  parameter int DATA_WIDTH          = 16
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  fft_repeating_buffer_if.slave strm
);

  localparam int DEPTH = 2 * FFT_LENGTH;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(FFT_LENGTH) + 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(FFT_LENGTH - 1);
  localparam logic [CW-1:0] NEW_LAST = CW'(NEW_SAMPLES_PER_FFT - 1);
  localparam logic [AW-1:0] LEN_A    = AW'(FFT_LENGTH);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   prime_cnt_q, prime_cnt_d;
  logic            primed_q, primed_d;
  logic [CW-1:0]   new_cnt_q, new_cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   iss_cnt_q, iss_cnt_d;
  logic            pend_q, pend_d;
  logic [AW-1:0]   pend_addr_q, pend_addr_d;
  logic            ovf_q, ovf_d;

  logic                  s1_vld_q, s1_vld_d;
  logic                  s1_last_q, s1_last_d;
  logic [DATA_WIDTH-1:0] s1_dat_q;
  logic                  o_valid_q, o_valid_d;
  logic                  o_last_q, o_last_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;

  logic          trig;
  logic [AW-1:0] trig_addr;
  logic          adv;
  logic          rd_en;
  logic          frame_end;

  // Frame start points FFT_LENGTH samples behind the slot after the trigger write.
  assign trig_addr = wr_ptr_q + AW'(1) - LEN_A;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    new_cnt_d   = new_cnt_q;
    trig        = 1'b0;
    if (strm.i_valid) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (!primed_q) begin
        prime_cnt_d = prime_cnt_q + CW'(1);
        if (prime_cnt_q == LAST_IDX) begin
          trig      = 1'b1;
          primed_d  = 1'b1;
          new_cnt_d = '0;
        end
      end else if (new_cnt_q == NEW_LAST) begin
        trig      = 1'b1;
        new_cnt_d = '0;
      end else begin
        new_cnt_d = new_cnt_q + CW'(1);
      end
    end
  end

  // Reads are issued ahead of the transfer; the pipeline only moves when the
  // output register is empty or being consumed, so nothing is skipped or repeated.
  assign adv       = !o_valid_q || strm.i_ready;
  assign rd_en     = (state_q == ST_SEND) && (!s1_vld_q || adv);
  assign frame_end = rd_en && (iss_cnt_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    iss_cnt_d   = iss_cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (trig) begin
          state_d   = ST_SEND;
          rd_ptr_d  = trig_addr;
          iss_cnt_d = '0;
        end
      end
      ST_SEND: begin
        if (rd_en) begin
          rd_ptr_d  = rd_ptr_q + AW'(1);
          iss_cnt_d = iss_cnt_q + CW'(1);
        end
        if (frame_end) begin
          iss_cnt_d = '0;
          if (pend_q) begin
            rd_ptr_d = pend_addr_q;
            pend_d   = trig;
            if (trig) pend_addr_d = trig_addr;
          end else if (trig) begin
            rd_ptr_d = trig_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (trig) begin
          if (!pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = trig_addr;
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_last_d = s1_last_q;
    o_valid_d = o_valid_q;
    o_last_d  = o_last_q;
    o_data_d  = o_data_q;
    if (rd_en) begin
      s1_vld_d  = 1'b1;
      s1_last_d = (iss_cnt_q == LAST_IDX);
    end else if (adv) begin
      s1_vld_d = 1'b0;
    end
    if (adv) begin
      o_valid_d = s1_vld_q;
      o_last_d  = s1_vld_q && s1_last_q;
      o_data_d  = s1_vld_q ? s1_dat_q : o_data_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
      new_cnt_q   <= '0;
      rd_ptr_q    <= '0;
      iss_cnt_q   <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      ovf_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      o_valid_q   <= 1'b0;
      o_last_q    <= 1'b0;
      o_data_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      new_cnt_q   <= new_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      iss_cnt_q   <= iss_cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      ovf_q       <= ovf_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      o_valid_q   <= o_valid_d;
      o_last_q    <= o_last_d;
      o_data_q    <= o_data_d;
    end
  end

  // Same-address write and read on one edge returns the previous contents.
  always_ff @(posedge i_clk) begin
    if (strm.i_valid) mem[wr_ptr_q] <= strm.i_data;
    if (rd_en) s1_dat_q <= mem[rd_ptr_q];
  end

  assign strm.o_data     = o_data_q;
  assign strm.o_valid    = o_valid_q;
  assign strm.o_last     = o_last_q;
  assign strm.o_overflow = ovf_q;

endmodule

// File: tb/tb_fft_repeating_buffer.sv
// Directed bench: two instances (NEW=2 and NEW=8, FFT_LENGTH=8) fed the same stream.
module tb_fft_repeating_buffer;
  localparam int N  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid;
  logic [DW-1:0] din;
  logic          ready;
  int            rdy_mode = 0;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_repeating_buffer_if #(.DATA_WIDTH(DW)) ifa ();
  fft_repeating_buffer_if #(.DATA_WIDTH(DW)) ifb ();

  assign ifa.i_valid = valid;
  assign ifa.i_data  = din;
  assign ifa.i_ready = ready;
  assign ifb.i_valid = valid;
  assign ifb.i_data  = din;
  assign ifb.i_ready = ready;

  fft_repeating_buffer #(.FFT_LENGTH(N), .NEW_SAMPLES_PER_FFT(2), .DATA_WIDTH(DW)) u_a (
    .i_clk(clk), .i_resetn(rst_n), .strm(ifa));
  fft_repeating_buffer #(.FFT_LENGTH(N), .NEW_SAMPLES_PER_FFT(8), .DATA_WIDTH(DW)) u_b (
    .i_clk(clk), .i_resetn(rst_n), .strm(ifb));

  typedef struct { int dat; int last; int cyc; } tr_t;
  typedef struct { int prev; int cur; int vld; } hold_t;
  typedef struct { int sel; int nsamp; int gap; int rmode; int nfr; int f0; int f1; int f2; } vec_t;

  tr_t   tra[$], trb[$];
  hold_t hla[$], hlb[$];
  int    rsa[$], rsb[$];

  // ready: 0 = low, 1 = high, 2 = random per cycle
  initial begin
    ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  logic sa_prev = 1'b0, va_prev = 1'b0, sb_prev = 1'b0, vb_prev = 1'b0;
  int   da_prev = 0, db_prev = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      sa_prev <= 1'b0;
      va_prev <= 1'b0;
    end else begin
      if (sa_prev) hla.push_back('{da_prev, int'(ifa.o_data), int'(ifa.o_valid)});
      if (ifa.o_valid && !va_prev) rsa.push_back(cyc);
      if (ifa.o_valid && ready) tra.push_back('{int'(ifa.o_data), int'(ifa.o_last), cyc});
      sa_prev <= ifa.o_valid && !ready;
      da_prev <= int'(ifa.o_data);
      va_prev <= ifa.o_valid;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_prev <= 1'b0;
      vb_prev <= 1'b0;
    end else begin
      if (sb_prev) hlb.push_back('{db_prev, int'(ifb.o_data), int'(ifb.o_valid)});
      if (ifb.o_valid && !vb_prev) rsb.push_back(cyc);
      if (ifb.o_valid && ready) trb.push_back('{int'(ifb.o_data), int'(ifb.o_last), cyc});
      sb_prev <= ifb.o_valid && !ready;
      db_prev <= int'(ifb.o_data);
      vb_prev <= ifb.o_valid;
    end
  end

  function automatic int ntr(input int sel);
    return (sel != 0) ? trb.size() : tra.size();
  endfunction
  function automatic int nhl(input int sel);
    return (sel != 0) ? hlb.size() : hla.size();
  endfunction
  function automatic int nrs(input int sel);
    return (sel != 0) ? rsb.size() : rsa.size();
  endfunction
  function automatic tr_t get_tr(input int sel, input int idx);
    return (sel != 0) ? trb[idx] : tra[idx];
  endfunction
  function automatic hold_t get_hl(input int sel, input int idx);
    return (sel != 0) ? hlb[idx] : hla[idx];
  endfunction
  function automatic int get_rs(input int sel, input int idx);
    return (sel != 0) ? rsb[idx] : rsa[idx];
  endfunction
  function automatic int ovf(input int sel);
    return (sel != 0) ? int'(ifb.o_overflow) : int'(ifa.o_overflow);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input int v, input int gap, output int acc);
    valid = 1'b1;
    din   = DW'(v);
    @(posedge clk);
    #1;
    acc   = cyc;
    valid = 1'b0;
    repeat (gap - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_tr(input int sel, input int target, input int budget);
    int c = 0;
    while (ntr(sel) < target && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
  endtask

  task automatic check_frames(input int sel, input int base, input int nfr, input int f0,
                              input int f1, input int f2, input int chk_cyc, input string tag);
    int firsts [3];
    tr_t t, tp;
    firsts[0] = f0;
    firsts[1] = f1;
    firsts[2] = f2;
    chk({tag, "_count"}, ntr(sel) - base, nfr * N);
    for (int fr = 0; fr < nfr; fr++) begin
      for (int i = 0; i < N; i++) begin
        int idx = base + fr * N + i;
        if (idx < ntr(sel)) begin
          t = get_tr(sel, idx);
          chk($sformatf("%s_f%0d_dat%0d", tag, fr, i), t.dat, firsts[fr] + i);
          chk($sformatf("%s_f%0d_last%0d", tag, fr, i), t.last, (i == N - 1) ? 1 : 0);
          if (chk_cyc != 0 && i > 0) begin
            tp = get_tr(sel, idx - 1);
            chk($sformatf("%s_f%0d_b2b%0d", tag, fr, i), t.cyc, tp.cyc + 1);
          end
        end
      end
    end
  endtask

  task automatic check_holds(input int sel, input int base, input string tag);
    hold_t h;
    for (int i = base; i < nhl(sel); i++) begin
      h = get_hl(sel, i);
      chk({tag, "_hold_vld"}, h.vld, 1);
      chk({tag, "_hold_dat"}, h.cur, h.prev);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [3];
    vec_t v;
    int tb, hb, rb, acc, acc8;

    vt[0] = '{0, 12, 32, 1, 3, 1, 3, 5};
    vt[1] = '{0, 12, 32, 2, 3, 1, 3, 5};
    vt[2] = '{1, 16, 3, 1, 2, 1, 9, 0};

    rst_n = 1'b0;
    valid = 1'b0;
    din   = '0;
    #3;
    chk("rst_a_valid", int'(ifa.o_valid), 0);
    chk("rst_a_last", int'(ifa.o_last), 0);
    chk("rst_a_ovf", int'(ifa.o_overflow), 0);
    chk("rst_a_data", int'(ifa.o_data), 0);
    chk("rst_b_valid", int'(ifb.o_valid), 0);
    chk("rst_b_last", int'(ifb.o_last), 0);
    chk("rst_b_ovf", int'(ifb.o_overflow), 0);
    chk("rst_b_data", int'(ifb.o_data), 0);
    @(posedge clk);
    #1;

    for (int k = 0; k < 3; k++) begin
      v = vt[k];
      do_reset();
      tb = ntr(v.sel);
      hb = nhl(v.sel);
      rb = nrs(v.sel);
      acc8 = 0;
      rdy_mode = v.rmode;
      for (int s = 1; s <= v.nsamp; s++) begin
        send(s, v.gap, acc);
        if (s == N) acc8 = acc;
      end
      wait_tr(v.sel, tb + v.nfr * N, 300);
      repeat (20) @(posedge clk);
      #1;
      check_frames(v.sel, tb, v.nfr, v.f0, v.f1, v.f2, (v.rmode == 1) ? 1 : 0,
                   $sformatf("vec%0d", k));
      chk($sformatf("vec%0d_latency", k), (nrs(v.sel) > rb) ? get_rs(v.sel, rb) - acc8 : -1, 2);
      chk($sformatf("vec%0d_ovf", k), ovf(v.sel), 0);
      check_holds(v.sel, hb, $sformatf("vec%0d", k));
    end

    // Long stall: one frame in flight, one pending, the third trigger overflows.
    do_reset();
    tb = ntr(0);
    hb = nhl(0);
    rdy_mode = 0;
    for (int s = 1; s <= 12; s++) begin
      send(s, 1, acc);
      if (s == 11) chk("stall_ovf_before", ovf(0), 0);
    end
    chk("stall_ovf_set", ovf(0), 1);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_ovf_sticky", ovf(0), 1);
    chk("stall_held_valid", int'(ifa.o_valid), 1);
    chk("stall_held_data", int'(ifa.o_data), 1);
    rdy_mode = 1;
    wait_tr(0, tb + 2 * N, 100);
    repeat (30) @(posedge clk);
    #1;
    check_frames(0, tb, 2, 1, 3, 0, 1, "stall");
    chk("stall_ovf_after", ovf(0), 1);
    check_holds(0, hb, "stall");

    // Reset in the middle of the second frame, then re-prime from scratch.
    do_reset();
    tb = ntr(0);
    rdy_mode = 1;
    for (int s = 1; s <= 10; s++) send(s, (s == 10) ? 1 : 32, acc);
    wait_tr(0, tb + N + 3, 60);
    chk("midrst_progress", ntr(0) - tb, N + 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_drop", int'(ifa.o_valid), 0);
    chk("midrst_last_drop", int'(ifa.o_last), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tb = ntr(0);
    rb = nrs(0);
    acc8 = 0;
    for (int s = 101; s <= 108; s++) begin
      send(s, 4, acc);
      if (s == 108) acc8 = acc;
    end
    wait_tr(0, tb + N, 60);
    repeat (20) @(posedge clk);
    #1;
    check_frames(0, tb, 1, 101, 0, 0, 1, "reprime");
    chk("reprime_latency", (nrs(0) > rb) ? get_rs(0, rb) - acc8 : -1, 2);
    chk("reprime_ovf", ovf(0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
